// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin burst arbiter driving the 2-bit select of an external 4:1 mux.
// Optional forced release of long bursts is compiled in with `define ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int RESET_PTR = 0,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic [3:0] last_i,
  input  logic       ready_i,
  output logic [3:0] gnt_o,
  output logic [1:0] select_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic       state_dbg_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       beat;
  logic       nat_rel;
  logic       force_rel;
  logic       release_w;
  logic       load_grant;

  if (RESET_PTR < 0 || RESET_PTR > 3 || MAX_HOLD < 1 || (2 ** CNT_W) <= MAX_HOLD) begin : g_cfg_err
    $error("mux4_rr_arbiter: illegal RESET_PTR/MAX_HOLD/CNT_W combination");
  end

  // Downstream handshake: a beat transfers on any cycle where valid_o and ready_i are
  // both high; valid_o may stay high across ready_i-low stall cycles without a transfer.
  assign busy_o      = (state_q == S_GRANT);
  assign gnt_o       = gnt_q;
  assign select_o    = sel_q;
  assign valid_o     = busy_o & req_i[sel_q];
  assign state_dbg_o = state_q;

  assign beat      = valid_o & ready_i;
  assign nat_rel   = (beat & last_i[sel_q]) | ~req_i[sel_q];
  assign release_w = busy_o & (nat_rel | force_rel);

  // First pending requester at or above ptr_q, wrapping 3 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    load_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) load_grant = 1'b1;
      end
      S_GRANT: begin
        if (release_w) begin
          if (win_found) begin
            load_grant = 1'b1;
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
    // Advancing ptr past the winner gives a still-requesting releaser lowest priority.
    if (load_grant) begin
      state_d = S_GRANT;
      gnt_d   = 4'b0001 << win_idx;
      sel_d   = win_idx;
      ptr_d   = win_idx + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'(RESET_PTR);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  // Counter value MAX_HOLD-1 marks the last permitted cycle of the current grant.
  assign force_rel = busy_o && (cnt_q == CNT_W'(MAX_HOLD - 1)) && !nat_rel;
  assign timeout_o = timeout_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_grant) begin
      cnt_d = '0;
    end else if (busy_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= force_rel;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_i)
    $onehot0(gnt_o) && (busy_o == (gnt_o != 4'b0000)));

  a_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
    (busy_o && !release_w) |=> (busy_o && $stable(select_o)));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; expected values are hand-derived
// from the round-robin pointer sequence traced in the comments below.
module tb_mux4_rr_arbiter;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] req_i;
  logic [3:0] last_i;
  logic       ready_i;
  logic [3:0] gnt_o;
  logic [1:0] select_o;
  logic       valid_o;
  logic       busy_o;
  logic       timeout_o;
  logic       state_dbg_o;

  int n_checks;
  int n_errors;
  int beats;

  mux4_rr_arbiter #(
    .RESET_PTR (0),
    .MAX_HOLD  (4),
    .CNT_W     (3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .last_i      (last_i),
    .ready_i     (ready_i),
    .gnt_o       (gnt_o),
    .select_o    (select_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .state_dbg_o (state_dbg_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [1:0] exp_sel);
    check_eq({tag, "_sel"}, 8'(select_o), 8'(exp_sel));
    check_eq({tag, "_gnt"}, 8'(gnt_o), 8'(4'b0001 << exp_sel));
    check_eq({tag, "_busy"}, 8'(busy_o), 8'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_gnt"}, 8'(gnt_o), 8'h00);
    check_eq({tag, "_busy"}, 8'(busy_o), 8'd0);
    check_eq({tag, "_state"}, 8'(state_dbg_o), 8'd0);
  endtask

  initial begin
    logic [1:0] rr_seq [5];
    logic       rdy_tab [4];
    logic [3:0] last_tab [4];

    n_checks = 0;
    n_errors = 0;
    rst_i    = 1'b0;
    req_i    = 4'b0000;
    last_i   = 4'b0000;
    ready_i  = 1'b0;
    rr_seq   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rdy_tab  = '{1'b1, 1'b0, 1'b1, 1'b1};
    last_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};

    repeat (2) @(posedge clk_i);
    #2;
    check_idle("rst");
    check_eq("rst_sel", 8'(select_o), 8'd0);
    check_eq("rst_tmo", 8'(timeout_o), 8'd0);
    check_eq("rst_valid", 8'(valid_o), 8'd0);
    rst_i = 1'b1;
    step();
    check_idle("rst_noreq");

    // All four requesting single-beat bursts: 0,1,2,3,0 with no idle bubble.
    req_i   = 4'b1111;
    last_i  = 4'b1111;
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_grant($sformatf("rr%0d", i), rr_seq[i]);
    end
    check_eq("rr_valid", 8'(valid_o), 8'd1);
    req_i = 4'b0000;
    #1;
    check_eq("rr_abort_valid", 8'(valid_o), 8'd0);
    step();
    check_idle("rr_end");   // ptr = 1

    // Requester 2 alone, 3 beats with a stall on the second cycle.
    req_i  = 4'b0100;
    last_i = 4'b0000;
    beats  = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      ready_i = rdy_tab[i];
      last_i  = last_tab[i];
      #1;
      check_grant($sformatf("b3_c%0d", i), 2'd2);
      check_eq($sformatf("b3_valid%0d", i), 8'(valid_o), 8'd1);
      if (valid_o && ready_i) beats++;
      step();
    end
    check_eq("b3_beats", 8'(beats), 8'd3);
    // Still requesting and alone, so it wins again despite lowest priority.
    check_grant("b3_regrant", 2'd2);
    req_i   = 4'b0000;
    last_i  = 4'b0000;
    ready_i = 1'b1;
    step();
    check_idle("b3_end");   // ptr = 3

    // Requester 1 bursting; requester 3 arrives and must wait for last_i[1].
    req_i = 4'b0010;
    step();
    check_grant("np_g1", 2'd1);   // search 3,0,1 -> ptr = 2
    req_i  = 4'b1010;
    last_i = 4'b1000;             // last of a non-granted requester is ignored
    step();
    check_grant("np_hold1", 2'd1);
    step();
    check_grant("np_hold2", 2'd1);
    last_i = 4'b0010;
    #1;
    check_eq("np_last_valid", 8'(valid_o), 8'd1);
    step();
    check_grant("np_g3", 2'd3);   // ptr = 0
    last_i = 4'b0000;

    // Granted requester 3 aborts; requester 1 takes over next edge.
    req_i = 4'b0010;
    #1;
    check_eq("ab_valid", 8'(valid_o), 8'd0);
    step();
    check_grant("ab_g1", 2'd1);   // ptr = 2
    req_i = 4'b0000;
    step();
    check_idle("ab_end");

`ifdef ARB_TIMEOUT_EN
    // Requester 0 never sends last; forced release after 4 grant cycles hands over to 1.
    req_i = 4'b0011;
    step();
    check_grant("to_c0", 2'd0);   // search 2,3,0
    check_eq("to_c0_tmo", 8'(timeout_o), 8'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      check_grant($sformatf("to_c%0d", i), 2'd0);
      check_eq($sformatf("to_c%0d_tmo", i), 8'(timeout_o), 8'd0);
    end
    step();
    check_grant("to_next", 2'd1);
    check_eq("to_pulse", 8'(timeout_o), 8'd1);
    step();
    check_grant("to_after", 2'd1);
    check_eq("to_pulse_end", 8'(timeout_o), 8'd0);
    req_i = 4'b0000;
    step();
    check_idle("to_end");
`else
    // Without the timeout a last-less burst is held indefinitely.
    req_i = 4'b0001;
    step();
    check_grant("nt_g0", 2'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq($sformatf("nt_gnt%0d", i), 8'(gnt_o), 8'h01);
      check_eq($sformatf("nt_tmo%0d", i), 8'(timeout_o), 8'd0);
    end
    req_i = 4'b0000;
    step();
    check_idle("nt_end");
`endif

    // Asynchronous reset mid-grant drops the grant at once and restores ptr.
    req_i = 4'b0100;
    step();
    check_grant("mr_g2", 2'd2);   // ptr = 3 afterwards
    #1;
    rst_i = 1'b0;
    #1;
    check_idle("mr_rst");
    check_eq("mr_sel", 8'(select_o), 8'd0);
    check_eq("mr_valid", 8'(valid_o), 8'd0);
    req_i = 4'b1111;
    #2;
    rst_i = 1'b1;
    step();
    check_grant("mr_ptr", 2'd0);  // would be 3 if ptr survived reset

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
